// File: rtl/uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and constants for the two-requester AXI4-Lite UART arbiter.
//   arb_state_t : transaction FSM states (one transaction outstanding at a time)
//   OKAY/SLVERR : AXI response codes presented on RESP
//   rr_pick     : two-way round-robin selection given the favoured requester
// -----------------------------------------------------------------------------
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4
    } arb_state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // A lone requester always wins; on a tie the favoured one wins.
    // With no request the result is don't-care (the caller does not update).
    function automatic logic rr_pick(input logic [1:0] req, input logic prio);
        if (req == 2'b11) begin
            return prio;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin arbiter. The favoured-requester pointer flips to
// the loser of each accepted grant, so a requester that keeps asking cannot
// starve the other one.
//   clk    in  clock
//   srst   in  synchronous active-high reset (pointer favours requester 0)
//   req    in  [1:0] request vector
//   update in  grant accepted this cycle; advance the pointer
//   grant  out index of the winning requester (combinational)
// -----------------------------------------------------------------------------
module rr_arbiter2
    import uart_arb_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant
);

    logic prio_reg;

    assign grant = rr_pick(req, prio_reg);

    always_ff @(posedge clk) begin
        if (srst) begin
            prio_reg <= 1'b0;
        end else if (update) begin
            prio_reg <= ~grant;
        end
    end

endmodule

// File: rtl/uart_axil_arbiter.sv
// -----------------------------------------------------------------------------
// uart_axil_arbiter
// Arbitrates two simple request/ack clients onto one AXI4-Lite master port
// that talks to a UART slave. One transaction is in flight at a time; the
// winner's address, data and direction are latched at grant.
//
// Optional feature: define UART_ARB_TIMEOUT_EN to enable a watchdog that
// aborts any transaction lasting C_TIMEOUT_CYCLES cycles with SLVERR and
// RDATA=0. Without the macro no counter exists and the block waits forever.
//
// Ports
//   S_AXI_ACLK, S_AXI_ARESET        clock, synchronous active-high reset
//   REQ[1:0], REQ_WE[1:0]           per-requester request (held until ACK), 1=write
//   REQ_ADDR[2*AW], REQ_WDATA[2*DW] per-requester address / write data (slice i)
//   ACK[1:0]                        one-cycle completion pulse per requester
//   RDATA[DW], RESP[1:0]            read data and response, valid with ACK
//   M_AXI_AW*/W*/B*/AR*/R*          AXI4-Lite master channels to the UART slave
// -----------------------------------------------------------------------------
module uart_axil_arbiter
    import uart_arb_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_TIMEOUT_CYCLES   = 1024
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,

    input  logic [1:0]                      REQ,
    input  logic [1:0]                      REQ_WE,
    input  logic [2*C_M_AXI_ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [2*C_M_AXI_DATA_WIDTH-1:0] REQ_WDATA,
    output logic [1:0]                      ACK,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                      RESP,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,

    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;

    // ------------------------------------------------------------------
    // Per-requester views of the packed request buses
    // ------------------------------------------------------------------
    logic [AW-1:0] req_addr_arr  [2];
    logic [DW-1:0] req_wdata_arr [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_req_slice
        assign req_addr_arr[gi]  = REQ_ADDR[gi*AW +: AW];
        assign req_wdata_arr[gi] = REQ_WDATA[gi*DW +: DW];
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t    state_reg,    state_next;
    logic          grant_reg,    grant_next;
    logic [AW-1:0] addr_reg,     addr_next;
    logic [DW-1:0] wdata_reg,    wdata_next;
    logic          aw_pend_reg,  aw_pend_next;
    logic          w_pend_reg,   w_pend_next;
    logic [1:0]    ack_reg,      ack_next;
    logic [DW-1:0] rdata_reg,    rdata_next;
    logic [1:0]    resp_reg,     resp_next;

    logic          arb_grant;
    logic          arb_update;
    logic          tmo_fire;

    // Write-address / write-data beats still owed after this cycle
    logic          aw_left;
    logic          w_left;

    assign aw_left = aw_pend_reg & ~M_AXI_AWREADY;
    assign w_left  = w_pend_reg  & ~M_AXI_WREADY;

    rr_arbiter2 u_rr (
        .clk    (S_AXI_ACLK),
        .srst   (S_AXI_ARESET),
        .req    (REQ),
        .update (arb_update),
        .grant  (arb_grant)
    );

    // ------------------------------------------------------------------
    // Optional watchdog
    // ------------------------------------------------------------------
`ifdef UART_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(C_TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(C_TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_reg;

    // Counts busy cycles; restarts from 0 on the first cycle after a grant.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == IDLE) begin
            tmo_cnt_reg <= '0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end

    // Fires on the C_TIMEOUT_CYCLES-th busy cycle
    assign tmo_fire = (state_reg != IDLE) && (tmo_cnt_reg == TMO_LAST);
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = (C_TIMEOUT_CYCLES > 0);
    assign tmo_fire       = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        aw_pend_next = aw_pend_reg;
        w_pend_next  = w_pend_reg;
        ack_next     = 2'b00;
        rdata_next   = rdata_reg;
        resp_next    = resp_reg;
        arb_update   = 1'b0;

        case (state_reg)
            IDLE: begin
                // Skip the cycle in which ACK is visible: the finishing
                // requester has not had a chance to drop REQ yet, and a
                // request it still holds afterwards is a genuinely new one.
                if ((|REQ) && (ack_reg == 2'b00)) begin
                    arb_update   = 1'b1;
                    grant_next   = arb_grant;
                    addr_next    = req_addr_arr[arb_grant];
                    wdata_next   = req_wdata_arr[arb_grant];
                    aw_pend_next = 1'b1;
                    w_pend_next  = 1'b1;
                    state_next   = REQ_WE[arb_grant] ? WR_ADDR : RD_ADDR;
                end
            end

            WR_ADDR: begin
                aw_pend_next = aw_left;
                w_pend_next  = w_left;
                if (!aw_left && !w_left) begin
                    state_next = WR_RESP;
                end
            end

            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    ack_next[grant_reg] = 1'b1;
                    resp_next           = M_AXI_BRESP;
                    state_next          = IDLE;
                end
            end

            RD_ADDR: begin
                if (M_AXI_ARREADY) begin
                    state_next = RD_DATA;
                end
            end

            RD_DATA: begin
                if (M_AXI_RVALID) begin
                    ack_next[grant_reg] = 1'b1;
                    rdata_next          = M_AXI_RDATA;
                    resp_next           = M_AXI_RRESP;
                    state_next          = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Watchdog abort overrides whatever the slave did this cycle
        if (tmo_fire) begin
            ack_next            = 2'b00;
            ack_next[grant_reg] = 1'b1;
            resp_next           = SLVERR;
            rdata_next          = '0;
            state_next          = IDLE;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_reg   <= IDLE;
            grant_reg   <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            aw_pend_reg <= 1'b0;
            w_pend_reg  <= 1'b0;
            ack_reg     <= 2'b00;
            rdata_reg   <= '0;
            resp_reg    <= OKAY;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            aw_pend_reg <= aw_pend_next;
            w_pend_reg  <= w_pend_next;
            ack_reg     <= ack_next;
            rdata_reg   <= rdata_next;
            resp_reg    <= resp_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all VALID/READY are decoded from registered state)
    // ------------------------------------------------------------------
    assign M_AXI_AWADDR  = addr_reg;
    assign M_AXI_AWVALID = (state_reg == WR_ADDR) && aw_pend_reg;
    assign M_AXI_WDATA   = wdata_reg;
    assign M_AXI_WSTB    = '1;
    assign M_AXI_WVALID  = (state_reg == WR_ADDR) && w_pend_reg;
    assign M_AXI_BREADY  = (state_reg == WR_RESP);
    assign M_AXI_ARADDR  = addr_reg;
    assign M_AXI_ARVALID = (state_reg == RD_ADDR);
    assign M_AXI_RREADY  = (state_reg == RD_DATA);

    assign ACK   = ack_reg;
    assign RDATA = rdata_reg;
    assign RESP  = resp_reg;

endmodule

// File: tb/tb_uart_axil_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_axil_arbiter
// Directed bench for uart_axil_arbiter with a small AXI4-Lite slave model.
// Inputs are driven on the falling edge; outputs are read on the falling edge.
// The watchdog scenario follows UART_ARB_TIMEOUT_EN (C_TIMEOUT_CYCLES = 16).
// -----------------------------------------------------------------------------
module tb_uart_axil_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk  = 1'b0;
    logic              srst = 1'b1;
    logic [1:0]        req       = 2'b00;
    logic [1:0]        req_we    = 2'b00;
    logic [2*AW-1:0]   req_addr  = '0;
    logic [2*DW-1:0]   req_wdata = '0;
    logic [1:0]        ack;
    logic [DW-1:0]     rdata;
    logic [1:0]        resp;

    logic [AW-1:0]     m_awaddr;
    logic              m_awvalid;
    logic              m_awready;
    logic [DW-1:0]     m_wdata;
    logic [DW/8-1:0]   m_wstb;
    logic              m_wvalid;
    logic              m_wready;
    logic [1:0]        m_bresp;
    logic              m_bvalid;
    logic              m_bready;
    logic [AW-1:0]     m_araddr;
    logic              m_arvalid;
    logic              m_arready;
    logic [DW-1:0]     m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rvalid;
    logic              m_rready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_axil_arbiter #(
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (DW),
        .C_TIMEOUT_CYCLES   (16)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (srst),
        .REQ           (req),
        .REQ_WE        (req_we),
        .REQ_ADDR      (req_addr),
        .REQ_WDATA     (req_wdata),
        .ACK           (ack),
        .RDATA         (rdata),
        .RESP          (resp),
        .M_AXI_AWADDR  (m_awaddr),
        .M_AXI_AWVALID (m_awvalid),
        .M_AXI_AWREADY (m_awready),
        .M_AXI_WDATA   (m_wdata),
        .M_AXI_WSTB    (m_wstb),
        .M_AXI_WVALID  (m_wvalid),
        .M_AXI_WREADY  (m_wready),
        .M_AXI_BRESP   (m_bresp),
        .M_AXI_BVALID  (m_bvalid),
        .M_AXI_BREADY  (m_bready),
        .M_AXI_ARADDR  (m_araddr),
        .M_AXI_ARVALID (m_arvalid),
        .M_AXI_ARREADY (m_arready),
        .M_AXI_RDATA   (m_rdata),
        .M_AXI_RRESP   (m_rresp),
        .M_AXI_RVALID  (m_rvalid),
        .M_AXI_RREADY  (m_rready)
    );

    // ------------------------------------------------------------------
    // Slave model: AWREADY after aw_delay waiting cycles, WREADY always,
    // BVALID one cycle after both beats; ARREADY = ar_en, RVALID one cycle
    // after the AR beat unless r_hold.
    // ------------------------------------------------------------------
    int            aw_delay   = 0;
    logic          ar_en      = 1'b1;
    logic          r_hold     = 1'b0;
    logic [DW-1:0] r_data_val = '0;

    int            aw_cnt;
    logic          aw_got, w_got, bvalid_r, rvalid_r;
    logic [AW-1:0] cap_awaddr, cap_araddr;
    logic [DW-1:0] cap_wdata;
    logic [DW/8-1:0] cap_wstb;

    assign m_awready = (aw_cnt >= aw_delay);
    assign m_wready  = 1'b1;
    assign m_bvalid  = bvalid_r;
    assign m_bresp   = 2'b00;
    assign m_arready = ar_en;
    assign m_rvalid  = rvalid_r;
    assign m_rdata   = r_data_val;
    assign m_rresp   = 2'b00;

    always @(posedge clk) begin
        if (srst) begin
            aw_cnt     <= 0;
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            bvalid_r   <= 1'b0;
            rvalid_r   <= 1'b0;
            cap_awaddr <= '0;
            cap_araddr <= '0;
            cap_wdata  <= '0;
            cap_wstb   <= '0;
        end else begin
            if (m_awvalid && m_awready) begin
                aw_cnt     <= 0;
                cap_awaddr <= m_awaddr;
            end else if (m_awvalid) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (m_wvalid && m_wready) begin
                cap_wdata <= m_wdata;
                cap_wstb  <= m_wstb;
            end
            if (bvalid_r && m_bready) bvalid_r <= 1'b0;
            if ((aw_got || (m_awvalid && m_awready)) && (w_got || (m_wvalid && m_wready))) begin
                bvalid_r <= 1'b1;
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
            end else begin
                if (m_awvalid && m_awready) aw_got <= 1'b1;
                if (m_wvalid && m_wready)   w_got  <= 1'b1;
            end
            if (rvalid_r && m_rready) rvalid_r <= 1'b0;
            if (m_arvalid && m_arready) begin
                cap_araddr <= m_araddr;
                if (!r_hold) rvalid_r <= 1'b1;
            end
        end
    end

    // Running totals of cycles with AWVALID / WVALID / ACK high
    int mon_aw = 0, mon_w = 0, mon_ack = 0;

    always @(negedge clk) begin
        #1;
        if (m_awvalid)   mon_aw  = mon_aw + 1;
        if (m_wvalid)    mon_w   = mon_w + 1;
        if (ack != 2'b0) mon_ack = mon_ack + 1;
    end

    // Drive a request and wait (bounded) for its ACK; lat counts falling
    // edges from the drive edge to the ACK edge, -1 if none arrived.
    task automatic run_txn(input logic [1:0] r, input logic [1:0] we, input logic drop,
                           output int lat, output logic [1:0] ackv);
        req    = r;
        req_we = we;
        lat    = -1;
        ackv   = 2'b00;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                lat  = k;
                ackv = ack;
                break;
            end
        end
        if (drop) req = 2'b00;
        $display("txn: req=%b we=%b ack=%b lat=%0d resp=%b rdata=%h", r, we, ackv, lat, resp, rdata);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (ack !== 2'b00)   begin errors++; $display("FAIL reset_ack got=%b exp=00", ack); end
        checks++; if (rdata !== '0)    begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        checks++; if (resp !== 2'b00)  begin errors++; $display("FAIL reset_resp got=%b exp=00", resp); end
        checks++; if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 5'b0)
            begin errors++; $display("FAIL reset_handshake got=%b exp=00000",
                                     {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}); end
        srst = 1'b0;
        @(negedge clk);
        checks++; if ({m_awvalid, m_arvalid} !== 2'b00)
            begin errors++; $display("FAIL idle_valid got=%b exp=00", {m_awvalid, m_arvalid}); end
        $display("txn: reset released");
    endtask

    task automatic test_single_write();
        int lat;
        logic [1:0] av;
        req_addr[AW-1:0]  = 32'h0000_0004;
        req_wdata[DW-1:0] = 32'h0000_0041;
        run_txn(2'b01, 2'b01, 1'b1, lat, av);
        checks++; if (lat != 3)        begin errors++; $display("FAIL wr_latency got=%0d exp=3", lat); end
        checks++; if (av !== 2'b01)    begin errors++; $display("FAIL wr_ack got=%b exp=01", av); end
        checks++; if (resp !== 2'b00)  begin errors++; $display("FAIL wr_resp got=%b exp=00", resp); end
        checks++; if (cap_awaddr !== 32'h4)  begin errors++; $display("FAIL wr_awaddr got=%h exp=4", cap_awaddr); end
        checks++; if (cap_wdata !== 32'h41)  begin errors++; $display("FAIL wr_wdata got=%h exp=41", cap_wdata); end
        checks++; if (cap_wstb !== 4'hF)     begin errors++; $display("FAIL wr_wstb got=%h exp=f", cap_wstb); end
        @(negedge clk);
        checks++; if (ack !== 2'b00)   begin errors++; $display("FAIL wr_ack_width got=%b exp=00", ack); end
    endtask

    task automatic test_single_read();
        int lat;
        logic [1:0] av;
        r_data_val          = 32'h0000_005A;
        req_addr[2*AW-1:AW] = 32'h0000_0008;
        run_txn(2'b10, 2'b00, 1'b1, lat, av);
        checks++; if (lat != 3)          begin errors++; $display("FAIL rd_latency got=%0d exp=3", lat); end
        checks++; if (av !== 2'b10)      begin errors++; $display("FAIL rd_ack got=%b exp=10", av); end
        checks++; if (rdata !== 32'h5A)  begin errors++; $display("FAIL rd_rdata got=%h exp=5a", rdata); end
        checks++; if (resp !== 2'b00)    begin errors++; $display("FAIL rd_resp got=%b exp=00", resp); end
        checks++; if (cap_araddr !== 32'h8) begin errors++; $display("FAIL rd_araddr got=%h exp=8", cap_araddr); end
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [1:0]    exp_ack  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [AW-1:0] exp_addr [4] = '{32'h100, 32'h200, 32'h100, 32'h200};
        int lat;
        logic [1:0] av;
        req_addr[AW-1:0]     = 32'h0000_0100;
        req_addr[2*AW-1:AW]  = 32'h0000_0200;
        for (int t = 0; t < 4; t++) begin
            run_txn(2'b11, 2'b11, (t == 3), lat, av);
            checks++; if (av !== exp_ack[t])
                begin errors++; $display("FAIL rr_ack[%0d] got=%b exp=%b", t, av, exp_ack[t]); end
            checks++; if (cap_awaddr !== exp_addr[t])
                begin errors++; $display("FAIL rr_addr[%0d] got=%h exp=%h", t, cap_awaddr, exp_addr[t]); end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int aw0, w0, a0, lat;
        logic [1:0] av;
        aw_delay          = 4;
        req_addr[AW-1:0]  = 32'h0000_0010;
        req_wdata[DW-1:0] = 32'h0000_00A5;
        aw0 = mon_aw; w0 = mon_w; a0 = mon_ack;
        req = 2'b01; req_we = 2'b01;
        @(negedge clk);
        // Changing the request bus after grant must not leak into the beat
        req_addr[AW-1:0]  = 32'hDEAD_0000;
        req_wdata[DW-1:0] = 32'h0000_BEEF;
        lat = -1; av = 2'b00;
        for (int k = 2; k <= 30; k++) begin
            @(negedge clk);
            if (ack != 2'b00) begin lat = k; av = ack; break; end
        end
        req = 2'b00;
        $display("txn: backpressure ack=%b lat=%0d", av, lat);
        repeat (3) @(negedge clk);
        checks++; if (av !== 2'b01)         begin errors++; $display("FAIL bp_ack got=%b exp=01", av); end
        checks++; if (mon_aw - aw0 != 5)    begin errors++; $display("FAIL bp_awvalid_cycles got=%0d exp=5", mon_aw - aw0); end
        checks++; if (mon_w - w0 != 1)      begin errors++; $display("FAIL bp_wvalid_cycles got=%0d exp=1", mon_w - w0); end
        checks++; if (mon_ack - a0 != 1)    begin errors++; $display("FAIL bp_ack_count got=%0d exp=1", mon_ack - a0); end
        checks++; if (cap_awaddr !== 32'h10) begin errors++; $display("FAIL bp_latched_addr got=%h exp=10", cap_awaddr); end
        checks++; if (cap_wdata !== 32'hA5)  begin errors++; $display("FAIL bp_latched_data got=%h exp=a5", cap_wdata); end
        aw_delay = 0;
    endtask

    task automatic test_timeout();
        int lat;
        logic [1:0] av;
        ar_en = 1'b0;
        req_addr[AW-1:0] = 32'h0000_0020;
`ifdef UART_ARB_TIMEOUT_EN
        run_txn(2'b01, 2'b00, 1'b1, lat, av);
        checks++; if (lat != 17)        begin errors++; $display("FAIL tmo_latency got=%0d exp=17", lat); end
        checks++; if (av !== 2'b01)     begin errors++; $display("FAIL tmo_ack got=%b exp=01", av); end
        checks++; if (resp !== 2'b10)   begin errors++; $display("FAIL tmo_resp got=%b exp=10", resp); end
        checks++; if (rdata !== '0)     begin errors++; $display("FAIL tmo_rdata got=%h exp=0", rdata); end
        checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL tmo_arvalid got=%b exp=0", m_arvalid); end
        @(negedge clk);
`else
        begin
            int a0;
            a0 = mon_ack;
            req = 2'b01; req_we = 2'b00;
            lat = -1; av = 2'b00;
            repeat (40) @(negedge clk);
            checks++; if (mon_ack - a0 != 0) begin errors++; $display("FAIL stall_no_ack got=%0d exp=0", mon_ack - a0); end
            checks++; if (m_arvalid !== 1'b1) begin errors++; $display("FAIL stall_arvalid got=%b exp=1", m_arvalid); end
            $display("txn: stalled read held ARVALID for 40 cycles, aborting by reset");
            req  = 2'b00;
            srst = 1'b1;
            @(negedge clk);
            srst = 1'b0;
            @(negedge clk);
        end
`endif
        ar_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int lat, a0, k;
        logic [1:0] av;
        r_hold = 1'b1;
        req_addr[AW-1:0] = 32'h0000_0030;
        req = 2'b01; req_we = 2'b00;
        for (k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (m_rready) break;
        end
        checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL mid_reached_rd_data got=%b exp=1", m_rready); end
        a0   = mon_ack;
        srst = 1'b1;
        @(negedge clk);
        checks++; if (ack !== 2'b00)   begin errors++; $display("FAIL mid_ack got=%b exp=00", ack); end
        checks++; if (rdata !== '0)    begin errors++; $display("FAIL mid_rdata got=%h exp=0", rdata); end
        checks++; if (resp !== 2'b00)  begin errors++; $display("FAIL mid_resp got=%b exp=00", resp); end
        checks++; if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 5'b0)
            begin errors++; $display("FAIL mid_handshake got=%b exp=00000",
                                     {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}); end
        srst   = 1'b0;
        r_hold = 1'b0;
        req    = 2'b00;
        @(negedge clk);
        checks++; if (mon_ack - a0 != 0) begin errors++; $display("FAIL mid_no_ack got=%0d exp=0", mon_ack - a0); end
        $display("txn: read aborted by reset");
        req_addr[2*AW-1:AW] = 32'h0000_0040;
        run_txn(2'b11, 2'b00, 1'b1, lat, av);
        checks++; if (av !== 2'b01) begin errors++; $display("FAIL mid_regrant got=%b exp=01", av); end
        checks++; if (cap_araddr !== 32'h30) begin errors++; $display("FAIL mid_regrant_addr got=%h exp=30", cap_araddr); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
